// File: rtl/eth_pkt_arb.sv
// Two-input packet-atomic round-robin arbiter for the 64-bit packet stream.
// A 2-entry output FIFO decouples m_ready from the source ready signals.
module eth_pkt_arb #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s0_valid,
  input  logic               s0_sop,
  input  logic               s0_eop,
  input  logic               s0_error,
  input  logic [DATA_W-1:0]  s0_data,
  input  logic [EMPTY_W-1:0] s0_empty,
  output logic               s0_ready,
  input  logic               s1_valid,
  input  logic               s1_sop,
  input  logic               s1_eop,
  input  logic               s1_error,
  input  logic [DATA_W-1:0]  s1_data,
  input  logic [EMPTY_W-1:0] s1_empty,
  output logic               s1_ready,
  output logic               m_valid,
  output logic               m_sop,
  output logic               m_eop,
  output logic               m_error,
  output logic [DATA_W-1:0]  m_data,
  output logic [EMPTY_W-1:0] m_empty,
  input  logic               m_ready,
  output logic [1:0]         grant,
  output logic [1:0]         drop,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic               error;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } word_t;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  word_t            buf_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt1_q;

  logic  push, pop, inc0, inc1;
  word_t push_word;
  word_t head;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    drop      = 2'b00;
    push      = 1'b0;
    inc0      = 1'b0;
    inc1      = 1'b0;
    push_word = '{sop: s0_sop, eop: s0_eop, error: s0_error, empty: s0_empty, data: s0_data};
    if (state_q == GNT1)
      push_word = '{sop: s1_sop, eop: s1_eop, error: s1_error, empty: s1_empty, data: s1_data};

    unique case (state_q)
      IDLE: begin
        // Mid-packet words seen while idle are accepted and thrown away.
        s0_ready = s0_valid & ~s0_sop;
        s1_ready = s1_valid & ~s1_sop;
        drop     = {s1_ready, s0_ready};
        if (s0_valid && s0_sop && s1_valid && s1_sop)
          state_d = last_q ? GNT0 : GNT1;
        else if (s0_valid && s0_sop)
          state_d = GNT0;
        else if (s1_valid && s1_sop)
          state_d = GNT1;
      end
      GNT0: begin
        s0_ready = (cnt_q != 2'd2);
        push     = s0_valid & s0_ready;
        if (push && s0_eop) begin
          state_d = IDLE;
          last_d  = 1'b0;
          inc0    = 1'b1;
        end
      end
      GNT1: begin
        s1_ready = (cnt_q != 2'd2);
        push     = s1_valid & s1_ready;
        if (push && s1_eop) begin
          state_d = IDLE;
          last_d  = 1'b1;
          inc1    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pop   = (cnt_q != 2'd0) & m_ready;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      buf_q      <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_q ^ pop;
      wr_ptr_q <= wr_ptr_q ^ push;
      if (push)
        buf_q[wr_ptr_q] <= push_word;
      if (inc0)
        pkt_cnt0_q <= pkt_cnt0_q + CNT_W'(1);
      if (inc1)
        pkt_cnt1_q <= pkt_cnt1_q + CNT_W'(1);
    end
  end

  assign head     = buf_q[rd_ptr_q];
  assign m_valid  = (cnt_q != 2'd0);
  assign m_sop    = head.sop;
  assign m_eop    = head.eop;
  assign m_error  = head.error;
  assign m_empty  = head.empty;
  assign m_data   = head.data;
  assign grant    = state_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule
